// File: rtl/prog_bound_counter.sv
// ---------------------------------------------------------------------------
// prog_bound_counter
//   Programmable up/down bound counter with a prescaler, three terminal
//   modes (wrap, saturate, one-shot) and an IDLE/RUN/DONE run-control FSM.
//   Parallel load, count enable and bound compare behave as in the earlier
//   fixed up-counter; W, co, tick and busy are all registered, at_bound is
//   a combinational compare against the bound in the current direction.
// ---------------------------------------------------------------------------
module prog_bound_counter #(
   parameter int N     = 6,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [N-1:0]     par_load,
   input  logic             en,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [N-1:0]     lower_bound,
   input  logic [N-1:0]     upper_bound,
   input  logic [PRE_W-1:0] prescale,
   input  logic             start,
   input  logic             stop,
   output logic [N-1:0]     W,
   output logic             co,
   output logic             at_bound,
   output logic             busy,
   output logic             tick
);

   // Run-control states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Terminal-mode encodings; 2'b11 falls through to wrap.
   localparam logic [1:0] MODE_WRAP = 2'b00;
   localparam logic [1:0] MODE_SAT  = 2'b01;
   localparam logic [1:0] MODE_ONE  = 2'b10;

   state_t           state;
   logic [PRE_W-1:0] pre_cnt;

   // Prescaler has reached its programmed period on this cycle.
   logic pre_hit;
   // Counter is at or beyond the bound it is heading towards.
   logic terminal;
   // Value W takes on a step, and whether that step ends a one-shot run.
   logic [N-1:0] step_w;
   logic         step_done;

   assign pre_hit = (pre_cnt == prescale);

   // Direction-dependent bound compare, exposed directly as at_bound.
   assign at_bound = dir ? (W == lower_bound) : (W == upper_bound);

   // Terminal compare uses >= / <= so a value loaded outside the bounds,
   // or left there by a bound change, terminates on its next step.
   assign terminal = dir ? (W <= lower_bound) : (W >= upper_bound);

   // Next count value for a step: increment/decrement, or the mode's
   // terminal value once the bound has been reached.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      step_w    = dir ? (W - 1'b1) : (W + 1'b1);
      step_done = 1'b0;
      if (terminal) begin
         unique case (mode)
            MODE_SAT: begin
               step_w = dir ? lower_bound : upper_bound;
            end
            MODE_ONE: begin
               step_w    = dir ? lower_bound : upper_bound;
               step_done = 1'b1;
            end
            default: begin
               // Wrap (and the unused encoding): restart from the far bound.
               step_w = dir ? upper_bound : lower_bound;
            end
         endcase
      end
   end

   // Run-control FSM, prescaler and count register with registered flags.
   // Priority on each edge: load, then stop, then start, then step.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the values from before this edge, regardless of statement order.
      if (reset) begin
         state   <= IDLE;
         W       <= '0;
         pre_cnt <= '0;
         co      <= 1'b0;
         tick    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         // Pulses last one cycle unless re-asserted below.
         co   <= 1'b0;
         tick <= 1'b0;

         if (load) begin
            // Load overrides everything else on this edge; a coincident
            // step is dropped and the run state is left alone.
            W       <= par_load;
            pre_cnt <= '0;
         end else if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (start && (state != RUN)) begin
            state   <= RUN;
            busy    <= 1'b1;
            W       <= dir ? upper_bound : lower_bound;
            pre_cnt <= '0;
         end else if ((state == RUN) && en) begin
            if (pre_hit) begin
               pre_cnt <= '0;
               tick    <= 1'b1;
               W       <= step_w;
               co      <= terminal;
               if (step_done) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end else begin
               pre_cnt <= pre_cnt + 1'b1;
            end
         end
      end
   end

endmodule
